// File: rtl/io_input_pkg.sv
// Shared types and constants for the IO input window: debounce FSM states,
// default window base address and the switch-reader sub-addresses.
package io_input_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC70;

    localparam logic [2:0] SW_LO  = 3'b000;
    localparam logic [2:0] SW_LO2 = 3'b001;
    localparam logic [2:0] SW_HI  = 3'b010;
    localparam logic [2:0] SUBMIT = 3'b011;
    localparam logic [2:0] STATUS = 3'b100;

endpackage

// File: rtl/io_input_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, four-state debounce FSM with a saturating
// stability counter, and a registered one-cycle pulse on an accepted press.
module btn_debounce
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a one-cycle window the first stable sample already qualifies.
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES <= 1);

    logic [1:0]       sync_q;
    logic             level;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_SAT) ? c : c + CNT_ONE;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign level = sync_q[1];

    // The entry cycle into a WAIT state counts as the first stable sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (level) begin
                        if (SINGLE) begin
                            state_q <= PRESSED;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!level) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                PRESSED: begin
                    if (!level) begin
                        if (SINGLE) begin
                            state_q <= RELEASED;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (level) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped input window decode plus sticky, read-to-clear
// button event flags. Define IO_INPUT_OVF_EN to add the evt_overflow output.
module io_input_ctrl
    import io_input_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_submit,
    input  logic        btn_status,
    input  logic [31:0] addr,
    input  logic        io_read,
    output logic        switch_ctrl,
    output logic [2:0]  switch_addr,
    output logic        submit_evt,
`ifdef IO_INPUT_OVF_EN
    output logic        status_evt,
    output logic        evt_overflow
`else
    output logic        status_evt
`endif
);

    localparam logic [27:0] BASE_HI = IO_BASE[31:4];

    logic submit_rise;
    logic status_rise;
    logic rd_submit;
    logic rd_status;
    logic submit_evt_q;
    logic submit_evt_d;
    logic status_evt_q;
    logic status_evt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_submit (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (btn_submit),
        .rise_o (submit_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_status (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (btn_status),
        .rise_o (status_rise)
    );

    // Only even offsets 0x0..0x8 of the window map to switch-reader registers.
    assign switch_ctrl = io_read && (addr[31:4] == BASE_HI) &&
                         (addr[3:0] <= 4'h8) && !addr[0];
    assign switch_addr = addr[3:1];

    // A new press beats a coincident clearing read so no event is lost.
    always_comb begin
        rd_submit    = switch_ctrl && io_read && (switch_addr == SUBMIT);
        rd_status    = switch_ctrl && io_read && (switch_addr == STATUS);
        submit_evt_d = submit_rise || (submit_evt_q && !rd_submit);
        status_evt_d = status_rise || (status_evt_q && !rd_status);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            submit_evt_q <= 1'b0;
            status_evt_q <= 1'b0;
        end else begin
            submit_evt_q <= submit_evt_d;
            status_evt_q <= status_evt_d;
        end
    end

    assign submit_evt = submit_evt_q;
    assign status_evt = status_evt_q;

`ifdef IO_INPUT_OVF_EN
    logic ovf_set;
    logic rd_any;
    logic ovf_q;
    logic ovf_d;

    // Overflow marks a press merged into a flag that software has not yet read.
    always_comb begin
        ovf_set = (submit_rise && submit_evt_q && !rd_submit) ||
                  (status_rise && status_evt_q && !rd_status);
        rd_any  = rd_submit || rd_status;
        ovf_d   = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (rd_any) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign evt_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl with DEBOUNCE_CYCLES=4; event flag
// rises are matched against a queue of expected (flag, cycle) entries.
module tb_io_input_ctrl;

    localparam int DEB = 4;
    localparam int LAT = 2 + DEB + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_submit = 1'b0;
    logic        btn_status = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        io_read = 1'b0;
    logic        switch_ctrl;
    logic [2:0]  switch_addr;
    logic        submit_evt;
    logic        status_evt;
`ifdef IO_INPUT_OVF_EN
    logic        evt_overflow;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit is_status;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    logic prev_sub = 1'b0;
    logic prev_sta = 1'b0;

    io_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .IO_BASE(32'hFFFF_FC70)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_submit  (btn_submit),
        .btn_status  (btn_status),
        .addr        (addr),
        .io_read     (io_read),
        .switch_ctrl (switch_ctrl),
        .switch_addr (switch_addr),
        .submit_evt  (submit_evt),
`ifdef IO_INPUT_OVF_EN
        .status_evt  (status_evt),
        .evt_overflow(evt_overflow)
`else
        .status_evt  (status_evt)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every rising flag must match the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        logic now_v;
        logic was_v;
        for (int k = 0; k < 2; k++) begin
            now_v = (k == 1) ? status_evt : submit_evt;
            was_v = (k == 1) ? prev_sta : prev_sub;
            if (now_v && !was_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_rise_unexpected flag=%0d got rise at cycle %0d, required no rise", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_status !== bit'(k) || e.cyc !== cyc) begin
                        errors++;
                        $display("FAIL evt_rise flag=%0d cycle=%0d, required flag=%0d cycle=%0d",
                                 k, cyc, e.is_status, e.cyc);
                    end
                end
            end
        end
        prev_sub = submit_evt;
        prev_sta = status_evt;
    end

    task automatic test_reset();
        reset   = 1'b1;
        addr    = 32'hFFFF_FC76;
        io_read = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (submit_evt !== 1'b0) begin
            errors++; $display("FAIL reset_submit_evt got %b required 0", submit_evt);
        end
        checks++;
        if (status_evt !== 1'b0) begin
            errors++; $display("FAIL reset_status_evt got %b required 0", status_evt);
        end
        checks++;
        if (switch_ctrl !== 1'b1) begin
            errors++; $display("FAIL reset_switch_ctrl got %b required 1", switch_ctrl);
        end
        checks++;
        if (switch_addr !== 3'b011) begin
            errors++; $display("FAIL reset_switch_addr got %b required 011", switch_addr);
        end
`ifdef IO_INPUT_OVF_EN
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got %b required 0", evt_overflow);
        end
`endif
        io_read = 1'b0;
        addr    = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_decode();
        logic [31:0] ta [12];
        logic        trd [12];
        logic        tctl [12];
        logic [2:0]  tsa [12];
        ta   = '{32'hFFFF_FC70, 32'hFFFF_FC72, 32'hFFFF_FC74, 32'hFFFF_FC74,
                 32'hFFFF_FC76, 32'hFFFF_FC78, 32'hFFFF_FC7A, 32'hFFFF_FC71,
                 32'hFFFF_FC7C, 32'hFFFF_FD76, 32'h0000_0076, 32'hFFFF_FC7E};
        trd  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tctl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tsa  = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100,
                 3'b101, 3'b000, 3'b110, 3'b011, 3'b011, 3'b111};
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            addr    = ta[i];
            io_read = trd[i];
            #1;
            checks++;
            if (switch_ctrl !== tctl[i]) begin
                errors++;
                $display("FAIL decode_ctrl addr=%h got %b required %b", ta[i], switch_ctrl, tctl[i]);
            end
            checks++;
            if (switch_addr !== tsa[i]) begin
                errors++;
                $display("FAIL decode_subaddr addr=%h got %b required %b", ta[i], switch_addr, tsa[i]);
            end
        end
        @(negedge clock);
        io_read = 1'b0;
        addr    = 32'h0;
    endtask

    task automatic test_submit_press();
        @(negedge clock);
        btn_submit = 1'b1;
        exp_q.push_back('{is_status: 1'b0, cyc: cyc + LAT});
        repeat (LAT - 1) @(negedge clock);
        checks++;
        if (submit_evt !== 1'b0) begin
            errors++; $display("FAIL submit_early got %b required 0", submit_evt);
        end
        @(negedge clock);
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL submit_on_time got %b required 1", submit_evt);
        end
        repeat (10 - LAT) @(negedge clock);
        btn_submit = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL submit_sticky got %b required 1", submit_evt);
        end
        checks++;
        if (status_evt !== 1'b0) begin
            errors++; $display("FAIL submit_no_status got %b required 0", status_evt);
        end
    endtask

    task automatic test_status_glitch();
        @(negedge clock);
        btn_status = 1'b1;
        repeat (3) @(negedge clock);
        btn_status = 1'b0;
        repeat (12) @(negedge clock);
        checks++;
        if (status_evt !== 1'b0) begin
            errors++; $display("FAIL glitch_status got %b required 0", status_evt);
        end
    endtask

    task automatic test_clear_read();
        @(negedge clock);
        addr    = 32'hFFFF_FC78;
        io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL other_read_keeps_submit got %b required 1", submit_evt);
        end
        addr    = 32'hFFFF_FC76;
        io_read = 1'b1;
        #1;
        checks++;
        if (switch_ctrl !== 1'b1) begin
            errors++; $display("FAIL clear_read_ctrl got %b required 1", switch_ctrl);
        end
        checks++;
        if (switch_addr !== 3'b011) begin
            errors++; $display("FAIL clear_read_subaddr got %b required 011", switch_addr);
        end
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL flag_during_read got %b required 1", submit_evt);
        end
        @(negedge clock);
        io_read = 1'b0;
        addr    = 32'h0;
        checks++;
        if (submit_evt !== 1'b0) begin
            errors++; $display("FAIL submit_cleared got %b required 0", submit_evt);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clock);
        btn_status = 1'b1;
        exp_q.push_back('{is_status: 1'b1, cyc: cyc + LAT});
        repeat (9) @(negedge clock);
        btn_status = 1'b0;
        repeat (10) @(negedge clock);
        // Second press: the clearing read lands in the rise-pulse cycle.
        btn_status = 1'b1;
        repeat (LAT - 1) @(negedge clock);
        addr    = 32'hFFFF_FC78;
        io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        addr    = 32'h0;
        checks++;
        if (status_evt !== 1'b1) begin
            errors++; $display("FAIL set_wins_status got %b required 1", status_evt);
        end
`ifdef IO_INPUT_OVF_EN
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++; $display("FAIL set_wins_overflow got %b required 0", evt_overflow);
        end
`endif
        btn_status = 1'b0;
        repeat (10) @(negedge clock);
        addr    = 32'hFFFF_FC78;
        io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        addr    = 32'h0;
        checks++;
        if (status_evt !== 1'b0) begin
            errors++; $display("FAIL status_cleared got %b required 0", status_evt);
        end
    endtask

    task automatic test_merge();
        @(negedge clock);
        btn_submit = 1'b1;
        exp_q.push_back('{is_status: 1'b0, cyc: cyc + LAT});
        repeat (9) @(negedge clock);
        btn_submit = 1'b0;
        repeat (10) @(negedge clock);
        btn_submit = 1'b1;
        repeat (9) @(negedge clock);
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL merge_submit got %b required 1", submit_evt);
        end
`ifdef IO_INPUT_OVF_EN
        checks++;
        if (evt_overflow !== 1'b1) begin
            errors++; $display("FAIL merge_overflow got %b required 1", evt_overflow);
        end
`endif
        btn_submit = 1'b0;
        repeat (10) @(negedge clock);
`ifdef IO_INPUT_OVF_EN
        addr    = 32'hFFFF_FC78;
        io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_cleared got %b required 0", evt_overflow);
        end
`endif
        addr    = 32'hFFFF_FC76;
        io_read = 1'b1;
        @(negedge clock);
        io_read = 1'b0;
        addr    = 32'h0;
        checks++;
        if (submit_evt !== 1'b0) begin
            errors++; $display("FAIL merge_cleared got %b required 0", submit_evt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        btn_submit = 1'b1;
        repeat (4) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (submit_evt !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flag got %b required 0", submit_evt);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back('{is_status: 1'b0, cyc: cyc + LAT});
        repeat (LAT + 3) @(negedge clock);
        btn_submit = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (submit_evt !== 1'b1) begin
            errors++; $display("FAIL reset_mid_event got %b required 1", submit_evt);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_submit_press();
        test_status_glitch();
        test_clear_read();
        test_set_wins();
        test_merge();
        test_reset_mid();
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_events got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter IO_BASE, default 32'hFFFFFC70, base address of the input window.
REQ-003 SHALL have port clock  input  1  system clock; all state on posedge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_submit  input  1  raw asynchronous submit button.
REQ-006 SHALL have port btn_status  input  1  raw asynchronous status button.
REQ-007 SHALL have port addr  input  32  CPU data address.
REQ-008 SHALL have port io_read  input  1  CPU IO read strobe, one cycle per access.
REQ-009 SHALL have port switch_ctrl  output  1  select for the switch reader.
REQ-010 SHALL have port switch_addr  output  3  sub-address to the switch reader.
REQ-011 SHALL have port submit_evt  output  1  sticky submit event flag.
REQ-012 SHALL have port status_evt  output  1  sticky status event flag.

Function
REQ-013 SHALL drive switch_ctrl = 1 combinationally only when addr[31:4] == IO_BASE[31:4] and addr[3:0] <= 4'h8 and addr[0] == 0; else 0.
REQ-014 SHALL drive switch_addr = addr[3:1] (0x70/0x72 -> 000/001 switches[15:0], 0x74 -> 010 switches[23:16], 0x76 -> 011 submit, 0x78 -> 100 status).
REQ-015 SHALL pass each button through a 2-flop synchronizer before debounce; synchronizer adds exactly 2 cycles latency.
REQ-016 SHALL debounce each button with FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-017 RELEASED -> PRESS_WAIT on synced input 1; PRESS_WAIT -> RELEASED on input 0 (counter cleared); PRESS_WAIT -> PRESSED when input has been 1 for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 PRESSED -> RELEASE_WAIT on input 0; RELEASE_WAIT -> PRESSED on input 1 (counter cleared); RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES consecutive 0 cycles.
REQ-019 SHALL generate a one-cycle internal rise pulse exactly on the PRESS_WAIT -> PRESSED transition; no pulse on release.
REQ-020 Debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL saturate, never wrap.
REQ-021 SHALL set submit_evt (status_evt) on the cycle after its rise pulse and hold it until cleared.
REQ-022 SHALL clear submit_evt on the posedge ending a cycle with switch_ctrl=1, io_read=1, switch_addr=011; status_evt likewise with 100.
REQ-023 The flag SHALL remain 1 throughout the read cycle so the negedge-sampling reader returns 1.
REQ-024 Simultaneous rise pulse and clearing read on the same flag: set SHALL win; flag stays 1.
REQ-025 Multiple rise pulses while flag is 1 SHALL merge into one event.

Reset
REQ-026 On reset: submit_evt=0, status_evt=0, both FSMs RELEASED, counters 0, synchronizers 0; switch_ctrl/switch_addr follow inputs.
REQ-027 Reset asserted mid-debounce SHALL abort it with no event; a button held through reset release SHALL produce one event after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-028 With IO_INPUT_OVF_EN defined: output evt_overflow (1 bit) SHALL set when a rise pulse arrives while the corresponding flag is already 1 and not being cleared, and clear on any read of 0x76 or 0x78; reset value 0.
REQ-029 Without IO_INPUT_OVF_EN the port and its logic SHALL be absent; REQ-025 merging unchanged.

Structure
REQ-030 Package io_input_pkg SHALL hold the debounce state enum, IO_BASE default, and sub-address constants SW_LO=000, SW_LO2=001, SW_HI=010, SUBMIT=011, STATUS=100.
REQ-031 Sub-module btn_debounce (synchronizer + FSM + counter + rise pulse) SHALL be instantiated twice.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 btn_submit 0->1 held 10 cycles -> submit_evt 1 exactly 2+4+1 cycles after input edge; status_evt stays 0.
REQ-033 btn_status glitch 1 for 3 cycles then 0 -> no event; status_evt stays 0.
REQ-034 submit_evt=1, io_read=1 addr=0xFFFFFC76 -> switch_ctrl=1, switch_addr=011, submit_evt 0 next cycle.
REQ-035 Rise pulse coincident with clearing read of 0xFFFFFC78 -> status_evt remains 1; with IO_INPUT_OVF_EN, evt_overflow remains 0.
REQ-036 addr=0xFFFFFC74 -> switch_addr=010, switch_ctrl=io_read; addr=0xFFFFFC7A or 0xFFFFFC71 -> switch_ctrl=0.
REQ-037 Hold btn_submit, pulse reset at cycle 3 of debounce -> no event before release; event 2+4+1 cycles after reset deassertion.
